// File: rtl/tdm_pkg.sv
// tdm_pkg: shared definitions for the 8-slot TDM demultiplexer.
//   NSLOT / SLOT_W : number of slots per frame and width of the slot index
//   state_t        : frame FSM states (PAR is only entered when TDM_PARITY_EN is defined)
//   RST_WORD       : reset value for the output and partial-word registers
//   par9()         : even-parity check over 8 data bits plus the parity bit
package tdm_pkg;

    localparam int NSLOT  = 8;
    localparam int SLOT_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PAR  = 2'd2
    } state_t;

    localparam logic [NSLOT-1:0] RST_WORD = '0;

    // Returns 1 when the 9-bit frame has odd weight, i.e. even parity is violated.
    function automatic logic par9(input logic [NSLOT-1:0] w, input logic p);
        return (^w) ^ p;
    endfunction

endpackage

// File: rtl/tdm_demux8_dmx18.sv
// dmx18: combinational 1:8 slot decoder.
//   en  in  1       write strobe; no output is set when low
//   sel in  SLOT_W  slot index
//   we  out NSLOT   one-hot write enable, we[k] = en & (sel == k)
module dmx18
    import tdm_pkg::*;
(
    input  logic              en,
    input  logic [SLOT_W-1:0] sel,
    output logic [NSLOT-1:0]  we
);

    genvar k;
    generate
        for (k = 0; k < NSLOT; k++) begin : g_slot
            assign we[k] = en && (sel == SLOT_W'(k));
        end
    endgenerate

endmodule

// File: rtl/tdm_demux8.sv
// tdm_demux8: serial-to-parallel TDM demultiplexer. One bit per enabled clock is
// steered into slot s (0..7); a completed frame is presented on dout with a
// one-cycle valid pulse.
// Build option: define TDM_PARITY_EN to append a 9th even-parity bit per frame
// (adds the PAR state and drives err); undefined gives 8-bit frames, err tied 0.
// Ports:
//   clk   in  1  rising-edge clock
//   rst   in  1  asynchronous active-high reset
//   en    in  1  bit strobe; din/sync only sampled while high
//   sync  in  1  frame marker, marks slot 0 when high with en
//   din   in  1  serial data bit
//   dout  out 8  last completed frame, dout[k] = slot k
//   valid out 1  single-cycle pulse when dout is updated
//   s     out 3  slot the next enabled bit will fill
//   busy  out 1  frame in progress
//   err   out 1  parity error, pulses with valid
// Parameter SYNC_RESTART: 1 = sync mid-frame restarts at slot 0, 0 = treated as data.
module tdm_demux8
    import tdm_pkg::*;
#(
    parameter bit SYNC_RESTART = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              sync,
    input  logic              din,
    output logic [NSLOT-1:0]  dout,
    output logic              valid,
    output logic [SLOT_W-1:0] s,
    output logic              busy,
    output logic              err
);

    state_t           state;
    logic [NSLOT-1:0] word;
    logic [NSLOT-1:0] word_nxt;
    logic [NSLOT-1:0] we;
    logic             start;
    logic             cap;
    logic             last;

    // A frame starts on sync from IDLE always; mid-frame only when restart is allowed.
    assign start = en && sync && ((state == IDLE) || SYNC_RESTART);
    // Ordinary data capture into slot s.
    assign cap   = en && !start && (state == RUN);
    assign last  = cap && (s == SLOT_W'(NSLOT - 1));

    dmx18 u_dmx (
        .en  (cap),
        .sel (s),
        .we  (we)
    );

    always_comb begin
        word_nxt = word;
        for (int k = 0; k < NSLOT; k++) begin
            if (we[k]) word_nxt[k] = din;
        end
    end

    assign busy = (state != IDLE);

`ifdef TDM_PARITY_EN
    logic par_take;
    logic err_r;

    assign par_take = en && !start && (state == PAR);
    assign err      = err_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            word  <= RST_WORD;
            dout  <= RST_WORD;
            s     <= '0;
            valid <= 1'b0;
            err_r <= 1'b0;
        end else begin
            valid <= 1'b0;
            err_r <= 1'b0;
            if (start) begin
                // Partial word discarded; only slot 0 carries meaning now.
                word  <= {{(NSLOT-1){1'b0}}, din};
                s     <= SLOT_W'(1);
                state <= RUN;
            end else if (cap) begin
                word <= word_nxt;
                s    <= s + SLOT_W'(1);   // wraps to 0 after slot 7, so s reads 0 in PAR
                if (last) state <= PAR;
            end else if (par_take) begin
                dout  <= word;
                valid <= 1'b1;
                err_r <= par9(word, din);
                state <= IDLE;
            end
        end
    end
`else
    assign err = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            word  <= RST_WORD;
            dout  <= RST_WORD;
            s     <= '0;
            valid <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (start) begin
                // Partial word discarded; only slot 0 carries meaning now.
                word  <= {{(NSLOT-1){1'b0}}, din};
                s     <= SLOT_W'(1);
                state <= RUN;
            end else if (cap) begin
                word <= word_nxt;
                s    <= s + SLOT_W'(1);   // wraps to 0 after slot 7
                if (last) begin
                    dout  <= word_nxt;     // includes the slot 7 bit just taken
                    valid <= 1'b1;
                    state <= IDLE;
                end
            end
        end
    end
`endif

endmodule

// File: doc/tdm_demux8.md
# tdm_demux8

Serial-to-parallel time-division demultiplexer; the receiving end of the 8-channel bit-select mux path. It takes one serial bit per enabled clock, steers it into channel slot 0–7 under an internal slot counter, and presents the assembled 8-bit word with a one-cycle valid pulse. It sits downstream of any 8:1 mux stage driven by a free-running 3-bit select, and recovers `din[7:0]` from the mux output `y`.

## Interface
- `SYNC_RESTART`, default 1: 1 = `sync` during an active frame restarts the frame at slot 0; 0 = `sync` ignored mid-frame.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  bit strobe; `din`/`sync` sampled only when high.
- `sync`  in  1  frame marker; high with `en` = this bit is slot 0.
- `din`  in  1  serial data bit (mux output `y`).
- `dout`  out  8  last completed frame; `dout[k]` = slot k bit.
- `valid`  out  1  one-cycle pulse; `dout` updated.
- `s`  out  3  slot index the next enabled bit will fill; mirrors mux select.
- `busy`  out  1  frame in progress (state ≠ IDLE).
- `err`  out  1  parity error flag, pulses with `valid` (see Configuration).

## Operation
- States: IDLE, RUN, PAR (PAR exists only with the parity macro).
- IDLE: `s`=0. `en & sync` → capture `din` into slot 0, `s`←1, go to RUN. `en & ~sync` → bit discarded, stay IDLE.
- RUN: `en` → capture `din` into slot `s`, `s`←`s`+1. On capture of slot 7: without parity, `dout`←assembled word, `valid`←1, `s`←0 (wraps), go to IDLE; with parity, go to PAR.
- PAR: `en` → sample parity bit, `dout`←word, `valid`←1, `err`←mismatch, go to IDLE.
- `en` low: hold all state; `valid`/`err` drop after their single cycle.
- `sync & en` in RUN/PAR: with SYNC_RESTART=1, discard the partial word, capture `din` as slot 0, `s`←1, stay in RUN, no `valid`. With SYNC_RESTART=0, treat as an ordinary data bit.
- `sync` without `en`: ignored in all states.
- Back-to-back frames: `sync & en` on the cycle directly after the final slot is accepted; no dead cycle.
- The partial-word register is internal; `dout` changes only on frame completion.

## Timing
- Reset values: `dout`=8'h00, `valid`=0, `err`=0, `s`=0, `busy`=0, state IDLE, partial word 0.
- `rst` mid-frame clears everything immediately; the partial frame is lost and no `valid` is produced.
- Latency: `valid` and new `dout` are visible in the cycle after the clock edge that accepted the final bit (slot 7, or the parity bit).
- Minimum frame is 8 enabled cycles (9 with parity). `valid` is never high for 2 consecutive cycles.
- `s` is registered and updates on the same edge as the capture.

## Configuration
- `TDM_PARITY_EN` defined: each frame carries a 9th bit, even parity over the 8 data bits plus the parity bit. PAR state present. `err`=1 with `valid` when the XOR of all 9 bits is 1. `dout` is still updated on error. `s` reads 0 during PAR.
- Undefined: 8-bit frames, no PAR state, `err` tied 0.

## Structure
- Package `tdm_pkg`: `NSLOT`=8, `SLOT_W`=3, state enum (IDLE/RUN/PAR), reset word constant.
- Sub-module `dmx18`: combinational 1:8 decoder producing a one-hot slot write-enable from `s` and `en`. The top level holds the FSM, counter and registers.

## Test plan
- Reset then `sync`+`en` with bits 1,0,1,1,0,0,1,0 on slots 0–7 → `dout`=8'h4D, `valid` one cycle after slot 7, `s` back to 0.
- Two back-to-back frames 8'hA5 then 8'h3C, with `en` gapped low randomly inside the frames → two `valid` pulses, values correct, no extra pulses.
- `sync` at slot 4 with SYNC_RESTART=1 → first frame dropped, 8 bits later `valid` with the new word. With SYNC_RESTART=0 → completes the old frame with the `sync` bit as slot 4 data.
- `rst` asserted at slot 5 → outputs immediately at reset values, no `valid`; bits before the next `sync` are ignored.
- `TDM_PARITY_EN`: frame 8'h4D with parity 0 → `valid`, `err`=0; same frame with parity 1 → `valid`, `err`=1, `dout`=8'h4D.
